// File: rtl/keypad_hex_entry_pkg.sv
// rtl/keypad_hex_entry_pkg.sv - shared types, constants and decode helper for the keypad entry path
package keypad_pkg;

  typedef enum logic [1:0] {SCAN, DEBOUNCE, HELD} state_t;

  localparam logic [3:0] ROW_INIT = 4'b1110;
  localparam logic [3:0] NO_KEY   = 4'b1111;
  localparam int         KEY_W    = 4;

  // {valid, idx}: valid only when exactly one bit of the active-low vector is 0
  function automatic logic [2:0] onehot0_index(input logic [3:0] v);
    case (v)
      4'b1110: onehot0_index = 3'b100;
      4'b1101: onehot0_index = 3'b101;
      4'b1011: onehot0_index = 3'b110;
      4'b0111: onehot0_index = 3'b111;
      default: onehot0_index = 3'b000;
    endcase
  endfunction

endpackage

// File: rtl/keypad_hex_entry_if.sv
// rtl/keypad_hex_entry_if.sv - keypad matrix and hex entry result bundle
interface keypad_hex_entry_if;
  import keypad_pkg::*;

  logic [3:0]       col_n;
  logic [3:0]       row_n;
  logic             clr;
  logic [KEY_W-1:0] key_code;
  logic             key_valid;
  logic [15:0]      hexs;
  logic [2:0]       digits;

  modport master (
    input  col_n, clr,
    output row_n, key_code, key_valid, hexs, digits
  );

  modport slave (
    output col_n, clr,
    input  row_n, key_code, key_valid, hexs, digits
  );
endinterface

// File: rtl/keypad_hex_entry_col_sync.sv
// rtl/keypad_hex_entry_col_sync.sv - 2-flop synchroniser for the asynchronous keypad columns
module keypad_col_sync
  import keypad_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] d,
  output logic [3:0] q
);

  logic [3:0] meta;

  always_ff @(posedge clk) begin
    if (!rst) begin
      meta <= NO_KEY;
      q    <= NO_KEY;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/keypad_hex_entry.sv
// rtl/keypad_hex_entry.sv - 4x4 keypad scanner/debouncer feeding a 4-digit hex entry word; KEYPAD_REPEAT_EN adds auto-repeat
module keypad_hex_entry
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV     = 50000,
  parameter int DEBOUNCE_CNT = 4,
  parameter int REPEAT_TICKS = 100
) (
  input  logic clk,
  input  logic rst,
  keypad_hex_entry_if.master bus
);

  localparam int TW = $clog2(SCAN_DIV);
  localparam int CW = $clog2(DEBOUNCE_CNT + 1);
  localparam logic [TW-1:0] TICK_LAST = TW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] DB_LAST   = CW'(DEBOUNCE_CNT - 1);

  if (SCAN_DIV < 2 || DEBOUNCE_CNT < 1 || REPEAT_TICKS < 1) begin : g_bad_params
    $error("keypad_hex_entry: illegal parameter value");
  end

  logic [3:0]       col_s;
  logic [TW-1:0]    tick_cnt;
  logic             tick;
  state_t           state;
  logic [CW-1:0]    cnt;
  logic [3:0]       row_n;
  logic [3:0]       col_lat;
  logic [KEY_W-1:0] key_lat;
  logic [KEY_W-1:0] key_code;
  logic             key_valid;
  logic [15:0]      hexs;
  logic [2:0]       digits;
  logic [2:0]       r_info;
  logic [2:0]       c_info;
  logic [KEY_W-1:0] cur_val;
  logic             accept;
  logic [KEY_W-1:0] acc_val;

`ifdef KEYPAD_REPEAT_EN
  localparam int RW = $clog2(REPEAT_TICKS + 1);
  localparam logic [RW-1:0] RPT_LAST = RW'(REPEAT_TICKS - 1);
  logic [RW-1:0] rpt_cnt;
`endif

  keypad_col_sync u_sync (.clk(clk), .rst(rst), .d(bus.col_n), .q(col_s));

  assign tick    = (tick_cnt == TICK_LAST);
  assign r_info  = onehot0_index(row_n);
  assign c_info  = onehot0_index(col_s);
  assign cur_val = {r_info[1:0], c_info[1:0]};

  always_comb begin
    accept  = 1'b0;
    acc_val = key_lat;
    if (tick) begin
      case (state)
        SCAN: if (c_info[2] && DEBOUNCE_CNT == 1) begin
          accept  = 1'b1;
          acc_val = cur_val;
        end
        DEBOUNCE: accept = (col_s == col_lat) && (cnt == DB_LAST);
`ifdef KEYPAD_REPEAT_EN
        HELD: accept = (col_s != NO_KEY) && (rpt_cnt == RPT_LAST);
`endif
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      tick_cnt  <= '0;
      state     <= SCAN;
      cnt       <= '0;
      row_n     <= ROW_INIT;
      col_lat   <= NO_KEY;
      key_lat   <= '0;
      key_code  <= '0;
      key_valid <= 1'b0;
      hexs      <= '0;
      digits    <= '0;
`ifdef KEYPAD_REPEAT_EN
      rpt_cnt   <= '0;
`endif
    end else begin
      tick_cnt  <= tick ? '0 : tick_cnt + TW'(1);
      key_valid <= accept;
      if (accept) key_code <= acc_val;

      // clr outranks a simultaneous accept for the entry word only
      if (bus.clr) begin
        hexs   <= '0;
        digits <= '0;
      end else if (accept) begin
        hexs <= {hexs[11:0], acc_val};
        if (digits != 3'd4) digits <= digits + 3'd1;
      end

      if (tick) begin
        case (state)
          SCAN: begin
            if (c_info[2]) begin
              key_lat <= cur_val;
              col_lat <= col_s;
              if (DEBOUNCE_CNT == 1) begin
                state <= HELD;
                cnt   <= '0;
              end else begin
                state <= DEBOUNCE;
                cnt   <= CW'(1);
              end
            end else begin
              row_n <= {row_n[2:0], row_n[3]};
            end
          end
          DEBOUNCE: begin
            if (col_s != col_lat) begin
              state <= SCAN;
              cnt   <= '0;
            end else if (cnt == DB_LAST) begin
              state <= HELD;
              cnt   <= '0;
            end else begin
              cnt <= cnt + CW'(1);
            end
          end
          HELD: begin
            if (col_s != NO_KEY) begin
              cnt <= '0;
            end else if (cnt == DB_LAST) begin
              state <= SCAN;
              cnt   <= '0;
            end else begin
              cnt <= cnt + CW'(1);
            end
          end
          default: state <= SCAN;
        endcase
      end

`ifdef KEYPAD_REPEAT_EN
      if (state != HELD || (tick && col_s == NO_KEY)) rpt_cnt <= '0;
      else if (tick) rpt_cnt <= (rpt_cnt == RPT_LAST) ? '0 : rpt_cnt + RW'(1);
`endif
    end
  end

  assign bus.row_n     = row_n;
  assign bus.key_code  = key_code;
  assign bus.key_valid = key_valid;
  assign bus.hexs      = hexs;
  assign bus.digits    = digits;

endmodule

// File: tb/tb_keypad_hex_entry.sv
// tb/tb_keypad_hex_entry.sv - directed self-checking bench for keypad_hex_entry
module tb_keypad_hex_entry;

  localparam int SCAN_DIV     = 4;
  localparam int DEBOUNCE_CNT = 3;
  localparam int REPEAT_TICKS = 5;
  localparam int TICK         = SCAN_DIV;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  keypad_hex_entry_if kif();

  logic       clr_d     = 1'b0;
  logic       key_down  = 1'b0;
  logic       force_en  = 1'b0;
  logic [3:0] force_col = 4'hF;
  logic [1:0] kr = 2'd0;
  logic [1:0] kc = 2'd0;

  // keypad model: the pressed key pulls its column low only while its row is driven
  assign kif.clr   = clr_d;
  assign kif.col_n = force_en ? force_col :
                     (key_down && !kif.row_n[kr]) ? ~(4'b0001 << kc) : 4'b1111;

  keypad_hex_entry #(
    .SCAN_DIV(SCAN_DIV), .DEBOUNCE_CNT(DEBOUNCE_CNT), .REPEAT_TICKS(REPEAT_TICKS)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(kif)
  );

  int checks = 0;
  int errors = 0;
  int pulses = 0;
  int p0;
  bit ok;
  logic [3:0] r0;

  always @(negedge clk) if (kif.key_valid) pulses++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic clks(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic press(input logic [3:0] v, input int hold_ticks);
    kr = v[3:2];
    kc = v[1:0];
    key_down = 1'b1;
    clks(hold_ticks * TICK);
    key_down = 1'b0;
    clks(8 * TICK);
  endtask

  task automatic wait_pulse(input int limit, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < limit && !seen; i++) begin
      clks(1);
      if (kif.key_valid) seen = 1'b1;
    end
  endtask

  task automatic wait_row(input logic [3:0] v, input int limit, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < limit && !seen; i++) begin
      clks(1);
      if (kif.row_n == v) seen = 1'b1;
    end
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_row_n"},     kif.row_n,     4'b1110);
    check({tag, "_key_code"},  kif.key_code,  4'h0);
    check({tag, "_key_valid"}, kif.key_valid, 1'b0);
    check({tag, "_hexs"},      kif.hexs,      16'h0000);
    check({tag, "_digits"},    kif.digits,    3'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    logic [3:0] exp_rows [4];
    exp_rows[0] = 4'b1011;
    exp_rows[1] = 4'b0111;
    exp_rows[2] = 4'b1110;
    exp_rows[3] = 4'b1101;

    rst = 1'b0;
    clks(3);
    check_reset_state("reset");

    // idle scanning
    rst = 1'b1;
    p0  = pulses;
    wait_row(4'b1101, 20, ok);
    check("idle_first_rotate", ok, 1'b1);
    for (int i = 0; i < 4; i++) begin
      clks(TICK);
      check($sformatf("idle_row_%0d", i), kif.row_n, exp_rows[i]);
    end
    clks(4 * TICK);
    check("idle_no_pulse", pulses - p0, 0);

    // single press r=2 c=1 held 20 ticks
    p0 = pulses;
    press(4'h9, 20);
    check("single_pulses", pulses - p0, 1);
    check("single_key_code", kif.key_code, 4'h9);
    check("single_hexs", kif.hexs, 16'h0009);
    check("single_digits", kif.digits, 3'd1);

    clr_d = 1'b1;
    clks(1);
    clr_d = 1'b0;
    check("clr_hexs", kif.hexs, 16'h0000);
    check("clr_digits", kif.digits, 3'd0);

    // four digits then a fifth that pushes the oldest out
    press(4'h1, 16);
    press(4'h2, 16);
    press(4'h3, 16);
    press(4'h4, 16);
    check("four_hexs", kif.hexs, 16'h1234);
    check("four_digits", kif.digits, 3'd4);
    press(4'hA, 16);
    check("fifth_hexs", kif.hexs, 16'h234A);
    check("fifth_digits", kif.digits, 3'd4);
    check("fifth_key_code", kif.key_code, 4'hA);

    // bounce: one tick low, one tick high
    p0 = pulses;
    force_en = 1'b1;
    for (int i = 0; i < 6; i++) begin
      force_col = (i % 2 == 0) ? 4'b1101 : 4'b1111;
      clks(TICK);
    end
    force_col = 4'b1111;
    clks(2 * TICK);
    force_en = 1'b0;
    check("bounce_no_pulse", pulses - p0, 0);
    r0 = kif.row_n;
    ok = 1'b0;
    for (int i = 0; i < 3 * TICK && !ok; i++) begin
      clks(1);
      if (kif.row_n != r0) ok = 1'b1;
    end
    check("bounce_back_to_scan", ok, 1'b1);

    // two columns low together
    p0 = pulses;
    force_en  = 1'b1;
    force_col = 4'b1001;
    clks(8 * TICK);
    force_col = 4'b1111;
    clks(2 * TICK);
    force_en = 1'b0;
    check("multi_no_pulse", pulses - p0, 0);

    // clr held across the accept edge
    p0 = pulses;
    clr_d = 1'b1;
    kr = 2'd1;
    kc = 2'd1;
    key_down = 1'b1;
    wait_pulse(30 * TICK, ok);
    check("clrhit_seen", ok, 1'b1);
    check("clrhit_hexs", kif.hexs, 16'h0000);
    check("clrhit_digits", kif.digits, 3'd0);
    check("clrhit_key_code", kif.key_code, 4'h5);
    key_down = 1'b0;
    clr_d = 1'b0;
    clks(8 * TICK);
    check("clrhit_pulses", pulses - p0, 1);

    press(4'h6, 16);
    check("pre_rst_hexs", kif.hexs, 16'h0006);
    check("pre_rst_digits", kif.digits, 3'd1);

    // reset while debouncing key 5
    p0 = pulses;
    wait_row(4'b1011, 8 * TICK, ok);
    kr = 2'd1;
    kc = 2'd1;
    key_down = 1'b1;
    wait_row(4'b1101, 8 * TICK, ok);
    check("midrst_row_reached", ok, 1'b1);
    clks(6);
    check("midrst_no_pulse_yet", pulses - p0, 0);
    rst = 1'b0;
    clks(1);
    check_reset_state("midrst");
    rst = 1'b1;
    wait_pulse(40 * TICK, ok);
    check("redetect_seen", ok, 1'b1);
    check("redetect_key_code", kif.key_code, 4'h5);
    check("redetect_hexs", kif.hexs, 16'h0005);
    check("redetect_digits", kif.digits, 3'd1);
    key_down = 1'b0;
    clks(8 * TICK);

`ifdef KEYPAD_REPEAT_EN
    clr_d = 1'b1;
    clks(1);
    clr_d = 1'b0;
    p0 = pulses;
    kr = 2'd0;
    kc = 2'd3;
    key_down = 1'b1;
    wait_pulse(30 * TICK, ok);
    check("repeat_first_seen", ok, 1'b1);
    clks(17 * TICK);
    key_down = 1'b0;
    clks(8 * TICK);
    check("repeat_pulses", pulses - p0, 4);
    check("repeat_hexs", kif.hexs, 16'h3333);
    check("repeat_digits", kif.digits, 3'd4);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/keypad_hex_entry.md
Name: keypad_hex_entry

Overview:
- Input-side counterpart of the 4-digit seven-segment hex display path.
- Scans a 4x4 active-low matrix keypad, synchronises and debounces the columns, and decodes one key to a 4-bit hex value.
- Shifts each accepted key into a 16-bit word whose format matches the display's `hexs` input, so entered digits can be shown directly.

Parameters:
- SCAN_DIV, 50000: clk cycles per scan tick; each tick advances or samples the rows. Must be >= 2.
- DEBOUNCE_CNT, 4: consecutive identical ticks needed to accept a press or a release. Must be >= 1.
- REPEAT_TICKS, 100: ticks between auto-repeats. Used only with the optional feature.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-low (rst==0 resets on the clk edge)
- col_n  in  4  keypad columns, active-low, externally pulled up, asynchronous
- clr  in  1  synchronous clear of the entry word
- row_n  out  4  keypad row drive, active-low one-hot
- key_code  out  4  last accepted key value
- key_valid  out  1  one-cycle pulse per accepted key
- hexs  out  16  entered digits; newest digit in [3:0]
- digits  out  3  number of digits entered, saturates at 4

Behaviour:
- Reset (rst==0 at edge):
  - row_n=4'b1110, key_code=0, key_valid=0, hexs=0, digits=0.
  - tick counter=0, debounce counter=0, state=SCAN.
- col_n passes through a 2-flop synchroniser; all decisions use the synchronised value col_s.
- Tick: a counter runs 0..SCAN_DIV-1 and `tick` is asserted when it equals SCAN_DIV-1. Exactly one tick per SCAN_DIV cycles.
- Decode: row index r = position of the 0 in row_n; column index c = position of the 0 in col_s. Key value = {r[1:0], c[1:0]}.
- SCAN state, on tick:
  - col_s == 4'b1111: rotate row_n left (1110 -> 1101 -> 1011 -> 0111 -> 1110).
  - col_s has exactly one 0: latch r and c, set cnt=1, go to DEBOUNCE. row_n is frozen.
  - col_s has two or more 0s (ghosting or multi-key): ignore and rotate.
- DEBOUNCE state, on tick:
  - col_s equals the latched single-0 pattern: cnt++.
  - When cnt reaches DEBOUNCE_CNT: accept the key and go to HELD with cnt=0.
  - Any other pattern: go to SCAN, cnt=0, resume rotation from the current row.
  - If DEBOUNCE_CNT==1, the key is accepted on the same tick that leaves SCAN.
- Accept (registered at the accepting clk edge, so visible in the following cycle):
  - key_valid=1 for exactly one cycle; key_code=value.
  - hexs={hexs[11:0], value}; digits=min(digits+1, 4).
- HELD state, on tick:
  - col_s==4'b1111: cnt++; at DEBOUNCE_CNT go to SCAN (row rotation resumes on the next tick).
  - Otherwise: cnt=0. A second key on the same row is ignored.
- clr==1:
  - hexs=0, digits=0 that cycle.
  - If it coincides with an accept, clr wins: no shift, but key_valid still pulses and key_code still updates.
  - The FSM is unaffected.
- Reset mid-press: the FSM returns to SCAN. The held key is re-detected and re-debounced as a new press.
- hexs wraps by discarding its top nibble; there is no overflow flag.

Optional Feature:
- Macro KEYPAD_REPEAT_EN.
- Defined:
  - In HELD with the key still pressed, a repeat counter counts ticks.
  - At REPEAT_TICKS it re-accepts key_code: same pulse, shift and saturation rules as a normal accept. The counter then restarts.
  - Release or leaving HELD zeroes the counter.
- Undefined: the repeat counter and its logic are absent; one accept per press.

Decomposition:
- Package keypad_pkg holds:
  - FSM state enum: SCAN, DEBOUNCE, HELD.
  - Constants: ROW_INIT=4'b1110, NO_KEY=4'b1111, KEY_W=4.
  - Function onehot0_index returning {valid, idx[1:0]} for an active-low 4-bit vector.
- One sub-module, keypad_col_sync: a 4-bit 2-flop synchroniser with synchronous active-low reset to 4'b1111.

Test Plan:
- Idle: SCAN_DIV=4, DEBOUNCE_CNT=3, col_n=1111.
  - row_n cycles 1110, 1101, 1011, 0111 every 4 clks.
  - key_valid never pulses.
- Single press: press r=2, c=1 (col_n=1101 while row_n=1011) held for 20 ticks.
  - Exactly one key_valid pulse with key_code=0x9.
  - hexs=0x0009, digits=1.
- Four-digit entry: enter keys 1, 2, 3, 4 with full releases between them.
  - hexs=0x1234, digits=4.
  - A fifth key 0xA gives hexs=0x234A with digits still 4.
- Bounce rejection: toggle col_n with one tick low and one tick high for 6 ticks, then stay high.
  - No key_valid; FSM returns to SCAN.
  - Two columns low simultaneously also gives no key_valid.
- clr collision: assert clr on the exact key_valid cycle.
  - hexs=0 and digits=0, while key_code still updates.
  - Mid-debounce rst=0 pulse: all outputs return to reset values on the next edge.
- KEYPAD_REPEAT_EN, REPEAT_TICKS=5: hold key 0x3 for 17 ticks after acceptance.
  - 1+3 pulses total; hexs=0x3333.
